// File: rtl/core_probe.sv
// Run-control and statistics probe on the core retire interface: event counters, PC breakpoints, retire watchdog.
// Latency: trigger evaluated combinationally in cycle t; halt_req/cause/src and snapshot registered, visible at t+1.
// Backpressure: none on inputs; while halt_req is high all events are dropped until halt_ack returns the probe to RUN.
module core_probe #(
    parameter int XLEN    = 32,
    parameter int CNT_W   = 32,
    parameter int NUM_BP  = 4,
    parameter int TIMEOUT = 0
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic                                          i_clr,
    input  logic                                          i_retire_valid,
    input  logic [XLEN-1:0]                               i_retire_pc,
    input  logic                                          i_br_valid,
    input  logic                                          i_br_mispred,
    input  logic [NUM_BP*XLEN-1:0]                        i_bp_pc,
    input  logic [NUM_BP-1:0]                             i_bp_en,
    input  logic                                          i_halt_ack,
    output logic                                          o_halt_req,
    output logic [1:0]                                    o_halt_cause,
    output logic [((NUM_BP > 1) ? $clog2(NUM_BP) : 1)-1:0] o_halt_src,
    output logic [CNT_W-1:0]                              o_cnt_cycle,
    output logic [CNT_W-1:0]                              o_cnt_retire,
    output logic [CNT_W-1:0]                              o_cnt_br,
    output logic [CNT_W-1:0]                              o_cnt_hit,
    output logic [CNT_W-1:0]                              o_cnt_miss,
    output logic [CNT_W-1:0]                              o_snap_cycle,
    output logic [CNT_W-1:0]                              o_snap_retire,
    output logic [CNT_W-1:0]                              o_snap_br,
    output logic [CNT_W-1:0]                              o_snap_hit,
    output logic [CNT_W-1:0]                              o_snap_miss
);

    localparam int SRC_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;
    // Idle counter only needs to reach TIMEOUT-1; the trigger fires on the cycle that would reach TIMEOUT.
    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = (TIMEOUT > 0) ? IDLE_W'(TIMEOUT - 1) : '0;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_BP   = 2'd1;
    localparam logic [1:0] CAUSE_TO   = 2'd2;

    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

    state_t             r_state;
    logic               r_halt_req;
    logic [1:0]         r_halt_cause;
    logic [SRC_W-1:0]   r_halt_src;
    logic [IDLE_W-1:0]  r_idle;
    logic [CNT_W-1:0]   r_cnt_cycle, r_cnt_retire, r_cnt_br, r_cnt_hit, r_cnt_miss;
    logic [CNT_W-1:0]   r_snap_cycle, r_snap_retire, r_snap_br, r_snap_hit, r_snap_miss;

    logic               w_run;
    logic               w_bp_hit;
    logic [SRC_W-1:0]   w_bp_idx;
    logic               w_trig_bp;
    logic               w_trig_to;
    logic [IDLE_W-1:0]  w_idle_nxt;
    logic [CNT_W-1:0]   w_cycle_nxt, w_retire_nxt, w_br_nxt, w_hit_nxt, w_miss_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_run = (r_state == S_RUN);

    // Breakpoint comparators; scanning from the top down leaves the lowest matching index.
    always_comb begin
        w_bp_hit = 1'b0;
        w_bp_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (i_retire_valid && i_bp_en[i] && (i_bp_pc[i*XLEN +: XLEN] == i_retire_pc)) begin
                w_bp_hit = 1'b1;
                w_bp_idx = SRC_W'(i);
            end
        end
    end

    assign w_trig_bp = w_run && w_bp_hit;
    // clr zeroes the idle counter, so it also suppresses a timeout in the same cycle.
    assign w_trig_to = (TIMEOUT > 0) && w_run && !i_retire_valid && !i_clr && (r_idle == IDLE_LAST);

    // Next live counter values: clr wins, otherwise count only in RUN, saturating.
    always_comb begin
        w_cycle_nxt  = r_cnt_cycle;
        w_retire_nxt = r_cnt_retire;
        w_br_nxt     = r_cnt_br;
        w_hit_nxt    = r_cnt_hit;
        w_miss_nxt   = r_cnt_miss;
        if (i_clr) begin
            w_cycle_nxt  = '0;
            w_retire_nxt = '0;
            w_br_nxt     = '0;
            w_hit_nxt    = '0;
            w_miss_nxt   = '0;
        end else if (w_run) begin
            w_cycle_nxt = sat_inc(r_cnt_cycle);
            if (i_retire_valid) begin
                w_retire_nxt = sat_inc(r_cnt_retire);
            end
            if (i_br_valid) begin
                w_br_nxt = sat_inc(r_cnt_br);
                if (i_br_mispred) begin
                    w_miss_nxt = sat_inc(r_cnt_miss);
                end else begin
                    w_hit_nxt = sat_inc(r_cnt_hit);
                end
            end
        end
    end

    // Next idle count: restarts on a retire or on the timeout itself, frozen while halted.
    always_comb begin
        w_idle_nxt = r_idle;
        if (i_clr) begin
            w_idle_nxt = '0;
        end else if (w_run) begin
            if (i_retire_valid || w_trig_to || (TIMEOUT == 0)) begin
                w_idle_nxt = '0;
            end else begin
                w_idle_nxt = r_idle + IDLE_W'(1);
            end
        end
    end

    // RUN/HALT state machine with registered halt outputs, counters and snapshot capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_RUN;
            r_halt_req    <= 1'b0;
            r_halt_cause  <= CAUSE_NONE;
            r_halt_src    <= '0;
            r_idle        <= '0;
            r_cnt_cycle   <= '0;
            r_cnt_retire  <= '0;
            r_cnt_br      <= '0;
            r_cnt_hit     <= '0;
            r_cnt_miss    <= '0;
            r_snap_cycle  <= '0;
            r_snap_retire <= '0;
            r_snap_br     <= '0;
            r_snap_hit    <= '0;
            r_snap_miss   <= '0;
        end else begin
            r_idle       <= w_idle_nxt;
            r_cnt_cycle  <= w_cycle_nxt;
            r_cnt_retire <= w_retire_nxt;
            r_cnt_br     <= w_br_nxt;
            r_cnt_hit    <= w_hit_nxt;
            r_cnt_miss   <= w_miss_nxt;
            case (r_state)
                S_RUN: begin
                    if (w_trig_bp || w_trig_to) begin
                        r_state       <= S_HALT;
                        r_halt_req    <= 1'b1;
                        r_halt_cause  <= w_trig_bp ? CAUSE_BP : CAUSE_TO;
                        if (w_trig_bp) begin
                            r_halt_src <= w_bp_idx;
                        end
                        // Snapshot includes the triggering cycle's own events.
                        r_snap_cycle  <= w_cycle_nxt;
                        r_snap_retire <= w_retire_nxt;
                        r_snap_br     <= w_br_nxt;
                        r_snap_hit    <= w_hit_nxt;
                        r_snap_miss   <= w_miss_nxt;
                    end
                end
                S_HALT: begin
                    if (i_halt_ack) begin
                        r_state      <= S_RUN;
                        r_halt_req   <= 1'b0;
                        r_halt_cause <= CAUSE_NONE;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign o_halt_req    = r_halt_req;
    assign o_halt_cause  = r_halt_cause;
    assign o_halt_src    = r_halt_src;
    assign o_cnt_cycle   = r_cnt_cycle;
    assign o_cnt_retire  = r_cnt_retire;
    assign o_cnt_br      = r_cnt_br;
    assign o_cnt_hit     = r_cnt_hit;
    assign o_cnt_miss    = r_cnt_miss;
    assign o_snap_cycle  = r_snap_cycle;
    assign o_snap_retire = r_snap_retire;
    assign o_snap_br     = r_snap_br;
    assign o_snap_hit    = r_snap_hit;
    assign o_snap_miss   = r_snap_miss;

endmodule

// File: tb/tb_core_probe.sv
// Bench for core_probe: two instances (32-bit counters with TIMEOUT=5, 4-bit counters with watchdog off) on shared stimulus.
// Latency: expectations are queued per clock edge and popped by a monitor one half-cycle after that edge.
// Backpressure: none; the driver never waits on the DUT, so every loop is bounded by its own count.
module tb_core_probe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, clr, rv, bv, bm, ack;
    logic [31:0]  pc;
    logic [127:0] bpa;
    logic [3:0]   bpe;

    logic        h0, h1;
    logic [1:0]  c0, c1, s0, s1;
    logic [31:0] cc0, cr0, cb0, ch0, cm0, sc0, sr0, sb0, sh0, sm0;
    logic [3:0]  cc1, cr1, cb1, ch1, cm1, sc1, sr1, sb1, sh1, sm1;

    core_probe #(.XLEN(32), .CNT_W(32), .NUM_BP(4), .TIMEOUT(5)) u0 (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_retire_valid(rv), .i_retire_pc(pc),
        .i_br_valid(bv), .i_br_mispred(bm), .i_bp_pc(bpa), .i_bp_en(bpe), .i_halt_ack(ack),
        .o_halt_req(h0), .o_halt_cause(c0), .o_halt_src(s0),
        .o_cnt_cycle(cc0), .o_cnt_retire(cr0), .o_cnt_br(cb0), .o_cnt_hit(ch0), .o_cnt_miss(cm0),
        .o_snap_cycle(sc0), .o_snap_retire(sr0), .o_snap_br(sb0), .o_snap_hit(sh0), .o_snap_miss(sm0));

    core_probe #(.XLEN(32), .CNT_W(4), .NUM_BP(4), .TIMEOUT(0)) u1 (
        .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_retire_valid(rv), .i_retire_pc(pc),
        .i_br_valid(bv), .i_br_mispred(bm), .i_bp_pc(bpa), .i_bp_en(bpe), .i_halt_ack(ack),
        .o_halt_req(h1), .o_halt_cause(c1), .o_halt_src(s1),
        .o_cnt_cycle(cc1), .o_cnt_retire(cr1), .o_cnt_br(cb1), .o_cnt_hit(ch1), .o_cnt_miss(cm1),
        .o_snap_cycle(sc1), .o_snap_retire(sr1), .o_snap_br(sb1), .o_snap_hit(sh1), .o_snap_miss(sm1));

    // Counter index: 0 cycle, 1 retire, 2 br, 3 hit, 4 miss.
    typedef struct packed {
        logic            halt;
        logic [1:0]      cause;
        logic [1:0]      src;
        logic [31:0]     idle;
        logic [4:0][63:0] cnt;
        logic [4:0][63:0] snap;
    } mst_t;

    typedef struct packed {
        int   due;
        mst_t st;
    } exp_t;

    mst_t ms0, ms1, ob0, ob1;
    exp_t q0[$], q1[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        ob0 = '0;
        ob0.halt = h0; ob0.cause = c0; ob0.src = s0;
        ob0.cnt[0] = 64'(cc0); ob0.cnt[1] = 64'(cr0); ob0.cnt[2] = 64'(cb0); ob0.cnt[3] = 64'(ch0); ob0.cnt[4] = 64'(cm0);
        ob0.snap[0] = 64'(sc0); ob0.snap[1] = 64'(sr0); ob0.snap[2] = 64'(sb0); ob0.snap[3] = 64'(sh0); ob0.snap[4] = 64'(sm0);
    end

    always_comb begin
        ob1 = '0;
        ob1.halt = h1; ob1.cause = c1; ob1.src = s1;
        ob1.cnt[0] = 64'(cc1); ob1.cnt[1] = 64'(cr1); ob1.cnt[2] = 64'(cb1); ob1.cnt[3] = 64'(ch1); ob1.cnt[4] = 64'(cm1);
        ob1.snap[0] = 64'(sc1); ob1.snap[1] = 64'(sr1); ob1.snap[2] = 64'(sb1); ob1.snap[3] = 64'(sh1); ob1.snap[4] = 64'(sm1);
    end

    // Reference model: one clock edge of the probe as described behaviourally.
    function automatic mst_t model_next(mst_t s, logic [63:0] cmax, int tmo, bit r, bit c, bit v,
                                        logic [31:0] p, bit b, bit m, bit a,
                                        logic [127:0] bp_addr, logic [3:0] bp_on);
        mst_t       n;
        int         hit;
        bit         run, to;
        logic [4:0] inc;
        if (r) return '0;
        n   = s;
        hit = -1;
        run = !s.halt;
        for (int i = 0; i < 4; i++)
            if (hit < 0 && v && bp_on[i] && bp_addr[i*32 +: 32] == p) hit = i;
        inc = '0;
        if (run) begin
            inc[0] = 1'b1; inc[1] = v; inc[2] = b; inc[3] = b && !m; inc[4] = b && m;
        end
        for (int k = 0; k < 5; k++) begin
            if (c) n.cnt[k] = '0;
            else if (inc[k] && n.cnt[k] < cmax) n.cnt[k] = n.cnt[k] + 64'd1;
        end
        to = run && tmo > 0 && !c && !v && (s.idle + 1 == tmo);
        if (c) n.idle = 0;
        else if (run) n.idle = (v || to || tmo == 0) ? 32'd0 : s.idle + 32'd1;
        if (run && hit >= 0) begin
            n.halt = 1'b1; n.cause = 2'd1; n.src = 2'(hit); n.snap = n.cnt;
        end else if (run && to) begin
            n.halt = 1'b1; n.cause = 2'd2; n.snap = n.cnt;
        end else if (!run && a) begin
            n.halt = 1'b0; n.cause = 2'd0;
        end
        return n;
    endfunction

    task automatic cmp(string nm, logic [63:0] act, logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic check_state(string tag, mst_t o, mst_t e);
        string nm[5];
        nm[0] = "cycle"; nm[1] = "retire"; nm[2] = "br"; nm[3] = "hit"; nm[4] = "miss";
        cmp({tag, ".halt_req"}, 64'(o.halt), 64'(e.halt));
        cmp({tag, ".halt_cause"}, 64'(o.cause), 64'(e.cause));
        cmp({tag, ".halt_src"}, 64'(o.src), 64'(e.src));
        for (int k = 0; k < 5; k++) begin
            cmp($sformatf("%s.cnt_%s", tag, nm[k]), o.cnt[k], e.cnt[k]);
            cmp($sformatf("%s.snap_%s", tag, nm[k]), o.snap[k], e.snap[k]);
        end
    endtask

    // Monitor: pops every expectation whose edge has passed and compares against the DUT.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q0.size() > 0 && q0[0].due <= cyc) begin
                e = q0.pop_front();
                check_state("u0", ob0, e.st);
            end
            while (q1.size() > 0 && q1[0].due <= cyc) begin
                e = q1.pop_front();
                check_state("u1", ob1, e.st);
            end
        end
    end

    // Apply one cycle of stimulus, queue the expected post-edge state, return at the next falling edge.
    task automatic step(bit r, bit c, bit v, logic [31:0] p, bit b, bit m, bit a);
        exp_t e;
        rst = r; clr = c; rv = v; pc = p; bv = b; bm = m; ack = a;
        e.due = cyc + 1;
        ms0 = model_next(ms0, 64'hFFFF_FFFF, 5, r, c, v, p, b, m, a, bpa, bpe);
        e.st = ms0;
        q0.push_back(e);
        ms1 = model_next(ms1, 64'hF, 0, r, c, v, p, b, m, a, bpa, bpe);
        e.st = ms1;
        q1.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_n(int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 32'h0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; rv = 1'b0; pc = '0; bv = 1'b0; bm = 1'b0; ack = 1'b0;
        bpa = '0; bpe = '0; ms0 = '0; ms1 = '0;
        @(negedge clk);
        step(1, 0, 0, 32'h0, 0, 0, 0);
        step(1, 0, 0, 32'h0, 0, 0, 0);

        // Ten RUN cycles: 4 retires, 3 branches, one mispredicted.
        for (int k = 0; k < 10; k++)
            step(0, 0, (k < 8) && (k % 2 == 0), 32'h200, (k == 1) || (k == 3) || (k == 5), k == 5, 0);
        cmp("count.cycle", ob0.cnt[0], 10);
        cmp("count.retire", ob0.cnt[1], 4);
        cmp("count.br", ob0.cnt[2], 3);
        cmp("count.hit", ob0.cnt[3], 2);
        cmp("count.miss", ob0.cnt[4], 1);
        cmp("count.halt_req", 64'(ob0.halt), 0);

        // Single breakpoint on entry 2.
        bpa[2*32 +: 32] = 32'h23;
        bpe = 4'b0100;
        step(0, 0, 1, 32'h23, 0, 0, 0);
        cmp("bp.halt_req", 64'(ob0.halt), 1);
        cmp("bp.halt_cause", 64'(ob0.cause), 1);
        cmp("bp.halt_src", 64'(ob0.src), 2);
        cmp("bp.snap_retire", ob0.snap[1], 5);
        cmp("bp.snap_cycle", ob0.snap[0], 11);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 32'h10, 1, 1, 0);
        cmp("halted.cnt_retire", ob0.cnt[1], 5);
        cmp("halted.cnt_cycle", ob0.cnt[0], 11);
        cmp("halted.cnt_br", ob0.cnt[2], 3);

        // Reconfigure while halted: entries 1 and 3 both at 0x40.
        bpa[1*32 +: 32] = 32'h40;
        bpa[3*32 +: 32] = 32'h40;
        bpe = 4'b1010;
        step(0, 0, 0, 32'h0, 0, 0, 1);
        cmp("ack1.halt_req", 64'(ob0.halt), 0);
        step(0, 0, 1, 32'h40, 0, 0, 0);
        cmp("dual.halt_src", 64'(ob0.src), 1);
        cmp("dual.halt_cause", 64'(ob0.cause), 1);
        bpe = 4'b0000;
        step(0, 0, 0, 32'h0, 0, 0, 1);
        cmp("ack2.halt_req", 64'(ob0.halt), 0);
        cmp("ack2.halt_cause", 64'(ob0.cause), 0);
        cmp("ack2.cnt_cycle", ob0.cnt[0], 12);

        // Watchdog: retire at r, halt_req visible from r+6.
        step(0, 0, 1, 32'h100, 0, 0, 0);
        cmp("resume.cnt_cycle", ob0.cnt[0], 13);
        idle_n(4);
        cmp("wdog.early_halt_req", 64'(ob0.halt), 0);
        idle_n(1);
        cmp("wdog.halt_req", 64'(ob0.halt), 1);
        cmp("wdog.halt_cause", 64'(ob0.cause), 2);
        cmp("wdog.halt_src", 64'(ob0.src), 1);
        idle_n(1000);
        cmp("nowdog.halt_req", 64'(ob1.halt), 0);

        // Saturation of 4-bit counters, then clr against a branch.
        step(0, 1, 0, 32'h0, 0, 0, 0);
        for (int k = 0; k < 20; k++) step(0, 0, 0, 32'h0, 1, k % 3 == 0, 0);
        cmp("sat.cnt_br", ob1.cnt[2], 15);
        cmp("sat.cnt_hit", ob1.cnt[3], 13);
        cmp("sat.cnt_miss", ob1.cnt[4], 7);
        cmp("sat.cnt_cycle", ob1.cnt[0], 15);
        step(0, 1, 0, 32'h0, 1, 0, 0);
        cmp("clr.cnt_br", ob1.cnt[2], 0);
        cmp("clr.snap_br", ob1.snap[2], 3);

        // Reset while u0 is halted, together with ack and clr.
        step(1, 1, 0, 32'h0, 0, 0, 1);
        cmp("rsthalt.halt_req", 64'(ob0.halt), 0);
        cmp("rsthalt.halt_cause", 64'(ob0.cause), 0);
        cmp("rsthalt.halt_src", 64'(ob0.src), 0);
        cmp("rsthalt.snap_cycle", ob0.snap[0], 0);
        cmp("rsthalt.cnt_cycle", ob0.cnt[0], 0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if (k % 100 == 0) begin
                for (int i = 0; i < 4; i++) bpa[i*32 +: 32] = 32'($urandom_range(0, 7)) << 2;
                bpe = 4'($urandom);
            end
            step($urandom_range(0, 499) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
                 32'($urandom_range(0, 15)) << 2, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        end

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
